// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed byte frame into instruction memory
// and holds the CPU until a load completes with a good checksum.
module imem_loader #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        mem_we_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [8:0]  words_loaded_o
);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WR, CHK, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [7:0]    n_q, n_d, hi_q, hi_d, lo_q, lo_d, addr_q, addr_d, csum_q, csum_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          wait_st, accept;
    logic [8:0]    n_words;

    assign wait_st = state_q inside {COUNT, HI, LO, CHK};
    assign accept  = wait_st && in_valid_i;
    // A count byte of zero encodes a full 256-word image
    assign n_words = (n_q == 8'd0) ? 9'd256 : {1'b0, n_q};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        idle_d  = (wait_st && !accept) ? idle_q + 1'b1 : '0;
        case (state_q)
            IDLE, DONE, ERR: if (start_i) begin
                state_d = COUNT;
                cnt_d   = '0;
                addr_d  = '0;
                csum_d  = '0;
            end
            COUNT: if (accept) begin
                n_d     = in_data_i;
                state_d = HI;
            end
            HI: if (accept) begin
                hi_d    = in_data_i;
                csum_d  = csum_q ^ in_data_i;
                state_d = LO;
            end
            LO: if (accept) begin
                lo_d    = in_data_i;
                csum_d  = csum_q ^ in_data_i;
                state_d = WR;
            end
            WR: begin
                addr_d  = addr_q + 8'd1;
                cnt_d   = cnt_q + 9'd1;
                state_d = (cnt_q + 9'd1 == n_words) ? CHK : HI;
            end
            CHK: if (accept) state_d = (in_data_i == csum_q) ? DONE : ERR;
        endcase
        // A stalled source aborts the load; an accept on the same cycle still wins
        if (wait_st && !accept && idle_q == IW'(TIMEOUT)) state_d = ERR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
        end
    end

    assign in_ready_o     = wait_st;
    assign mem_we_o       = state_q == WR;
    assign mem_addr_o     = {8'h00, addr_q};
    assign mem_wdata_o    = {hi_q, lo_q};
    assign cpu_hold_o     = state_q != DONE;
    assign busy_o         = state_q inside {COUNT, HI, LO, WR, CHK};
    assign done_o         = state_q == DONE;
    assign err_o          = state_q == ERR;
    assign words_loaded_o = cnt_q;
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter TIMEOUT, default 1023, is the maximum number of idle cycles allowed between accepted bytes during a load.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a program load.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 mem_addr  output  16  instruction-memory word address; bits 15:8 are always 0.
REQ-010 mem_wdata  output  16  instruction word to write.
REQ-011 cpu_hold  output  1  keeps the processor stalled while the program is not valid.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  last load completed with a good checksum.
REQ-014 err  output  1  last load failed due to checksum mismatch or timeout.
REQ-015 words_loaded  output  9  count of words written in the current or last load.

Function
REQ-016 A byte SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1; in_ready=1 only in states COUNT, HI, LO and CHK.
REQ-017 FSM states SHALL be IDLE, COUNT, HI, LO, WR, CHK, DONE and ERR.
REQ-018 Start handling: start=1 in IDLE, DONE or ERR SHALL go to COUNT and clear done, err, words_loaded, the address counter and the checksum; cpu_hold=1 and busy=1 from the next cycle.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 Frame format: byte0 = word count N, where 0 means 256; then N words, each high byte first; then one checksum byte equal to the XOR of all 2N data bytes.
REQ-021 COUNT: accepting a byte latches N and moves to HI.
REQ-022 HI: accepting a byte latches the high byte, XORs it into the checksum and moves to LO.
REQ-023 LO: accepting a byte latches the low byte, XORs it into the checksum and moves to WR.
REQ-024 WR: for exactly one cycle with in_ready=0, mem_we=1, mem_addr=address counter and mem_wdata={hi,lo}.
REQ-025 WR: the address counter and words_loaded increment at the end of that cycle.
REQ-026 WR exit: go to CHK if words_loaded+1 = N, otherwise go to HI.
REQ-027 Address counter SHALL be 8 bits, start at 0 and increase by one per word; with N=256 the last write is to address 255 and no wrap write occurs.
REQ-028 CHK: an accepted byte equal to the running XOR SHALL go to DONE (done=1, cpu_hold=0, busy=0); otherwise go to ERR (err=1, cpu_hold=1, busy=0).
REQ-029 Idle counter SHALL count consecutive cycles in COUNT, HI, LO or CHK without an accepted byte, clearing on each accept and on entry to those states.
REQ-030 When the idle counter reaches TIMEOUT, the FSM SHALL go to ERR on the next edge; no further mem_we is issued.
REQ-031 mem_we SHALL be 0 in every state except WR; words already written by a failed load are not erased.
REQ-032 done and err SHALL never both be 1; both hold their value until the next start or rst.
REQ-033 Restart from DONE: start=1 in DONE SHALL reassert cpu_hold the following cycle.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE.
REQ-035 Output values while rst=1 and after its release SHALL be: cpu_hold=1, all other outputs 0, address/idle/checksum counters 0.
REQ-036 rst during a load SHALL abort it with no further writes and SHALL NOT alter memory contents.
REQ-037 While in IDLE after reset, cpu_hold SHALL remain 1 until a load reaches DONE.

Verification
REQ-038 Good load: start; bytes 02,12,34,AB,CD,checksum 40 -> writes (0,1234) and (1,ABCD), one mem_we cycle each; done=1, cpu_hold=0, words_loaded=2.
REQ-039 Bad checksum: same frame with checksum 41 -> two writes, err=1, done=0, cpu_hold=1.
REQ-040 Backpressure/gaps: in_valid toggled with 5-cycle gaps (TIMEOUT=1023) -> identical result to REQ-038; no byte is accepted in a WR cycle.
REQ-041 Timeout: TIMEOUT=16; send 01,12 then stop -> err=1 sixteen-plus cycles later, mem_we never asserted.
REQ-042 Full depth: N byte 00 followed by 512 bytes -> 256 writes at addresses 0..255, words_loaded=256, and the correct checksum gives done=1.
REQ-043 Reset mid-load: rst asserted after the 3rd word -> immediate IDLE with cpu_hold=1; start pressed during busy is ignored; a fresh load after reset succeeds.
